gshare_param: RTL and testbench

GSHARE_PARAM -- requirements
Module: gshare_param

---
 rtl/gshare_param.sv | 144 ++++++++++++++
 tb/tb_gshare_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_param.sv
// Gshare direction predictor: a PHT of saturating counters indexed by global
// history XOR branch PC, with a sweep-initialisation phase and a mispredict tally.
module gshare_param #(
  parameter int HIST_W   = 7,
  parameter int PC_W     = 7,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1,
  parameter int MISS_W   = 16
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              predict_valid,
  input  logic [PC_W-1:0]   predict_pc,
  output logic              predict_ready,
  output logic              predict_taken,
  output logic [HIST_W-1:0] predict_history,
  input  logic              train_valid,
  input  logic              train_taken,
  input  logic              train_mispredicted,
  input  logic [HIST_W-1:0] train_history,
  input  logic [PC_W-1:0]   train_pc,
  input  logic              clear_stats,
  output logic [MISS_W-1:0] mispredict_count,
  output logic              dbg_state
);

  // Handshake: a prediction fires in the cycle predict_valid & predict_ready;
  // the result is combinational in that same cycle. Training has no back-pressure.

  localparam int DEPTH = 1 << HIST_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [HIST_W-1:0]   ptr_q, ptr_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [CTR_W-1:0]    pht_q [DEPTH];

  logic                run;
  logic                pred_fire;
  logic [HIST_W-1:0]   pred_idx;
  logic [CTR_W-1:0]    pred_ctr;
  logic [HIST_W-1:0]   train_idx;
  logic [CTR_W-1:0]    train_ctr;
  logic [CTR_W-1:0]    train_ctr_nxt;
  logic                pht_we;
  logic [HIST_W-1:0]   pht_waddr;
  logic [CTR_W-1:0]    pht_wdata;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      hist_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hist_q  <= hist_d;
      miss_q  <= miss_d;
    end
  end

  // INIT sweeps the pointer across the whole table, leaving it wrapped to 0.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == {HIST_W{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    run           = (state_q == ST_RUN);
    predict_ready = run;
    dbg_state     = run;
  end

  always_comb begin
    pred_fire       = predict_valid & predict_ready;
    pred_idx        = hist_q ^ predict_pc[HIST_W-1:0];
    pred_ctr        = pht_q[pred_idx];
    predict_taken   = pred_fire & pred_ctr[CTR_W-1];
    predict_history = pred_fire ? hist_q : '0;
  end

  always_comb begin
    train_idx     = train_history ^ train_pc[HIST_W-1:0];
    train_ctr     = pht_q[train_idx];
    train_ctr_nxt = train_ctr;
    if (train_taken && (train_ctr != CTR_MAX))
      train_ctr_nxt = train_ctr + 1'b1;
    else if (!train_taken && (train_ctr != '0))
      train_ctr_nxt = train_ctr - 1'b1;
  end

  always_comb begin
    pht_we    = 1'b0;
    pht_waddr = train_idx;
    pht_wdata = train_ctr_nxt;
    if (!run) begin
      pht_we    = 1'b1;
      pht_waddr = ptr_q;
      pht_wdata = CTR_INIT;
    end else if (train_valid) begin
      pht_we    = 1'b1;
    end
  end

  // Table has no reset; INIT rewrites every entry after reset release.
  always_ff @(posedge clk) begin
    if (pht_we) pht_q[pht_waddr] <= pht_wdata;
  end

  // A mispredict repairs history from the trained branch, beating a speculative shift.
  always_comb begin
    hist_d = hist_q;
    if (run && train_valid && train_mispredicted)
      hist_d = {train_history[HIST_W-2:0], train_taken};
    else if (pred_fire)
      hist_d = {hist_q[HIST_W-2:0], predict_taken};
  end

  always_comb begin
    miss_d = miss_q;
    if (run) begin
      if (clear_stats)
        miss_d = '0;
      else if (train_valid && train_mispredicted && (miss_q != {MISS_W{1'b1}}))
        miss_d = miss_q + 1'b1;
    end
  end

  assign mispredict_count = miss_q;

endmodule

// File: tb/tb_gshare_param.sv
// Bench for gshare_param: behavioural model checked every cycle, plus directed
// scenarios with hand-computed expectations, then randomized traffic.
module tb_gshare_param;

  logic        clk;
  logic        areset_n;
  logic        predict_valid;
  logic [6:0]  predict_pc;
  logic        train_valid, train_taken, train_mispredicted;
  logic [6:0]  train_history, train_pc;
  logic        clear_stats;

  logic        predict_ready, predict_taken, dbg_state;
  logic [6:0]  predict_history;
  logic [15:0] mispredict_count;
  logic        predict_ready2, predict_taken2, dbg_state2;
  logic [6:0]  predict_history2;
  logic [1:0]  mispredict_count2;

  int n_checks = 0;
  int n_fail   = 0;

  gshare_param dut (
    .clk(clk), .areset_n(areset_n),
    .predict_valid(predict_valid), .predict_pc(predict_pc),
    .predict_ready(predict_ready), .predict_taken(predict_taken),
    .predict_history(predict_history),
    .train_valid(train_valid), .train_taken(train_taken),
    .train_mispredicted(train_mispredicted), .train_history(train_history),
    .train_pc(train_pc), .clear_stats(clear_stats),
    .mispredict_count(mispredict_count), .dbg_state(dbg_state)
  );

  gshare_param #(.MISS_W(2)) dut_small (
    .clk(clk), .areset_n(areset_n),
    .predict_valid(predict_valid), .predict_pc(predict_pc),
    .predict_ready(predict_ready2), .predict_taken(predict_taken2),
    .predict_history(predict_history2),
    .train_valid(train_valid), .train_taken(train_taken),
    .train_mispredicted(train_mispredicted), .train_history(train_history),
    .train_pc(train_pc), .clear_stats(clear_stats),
    .mispredict_count(mispredict_count2), .dbg_state(dbg_state2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // behavioural model: table contents, history, tally, cycles spent initialising
  int m_pht [128];
  int m_hist = 0;
  int m_cnt  = 0;
  int m_init = 0;

  always @(negedge clk) begin : model_cmp
    int idx, e_taken, e_hist, e_ready, e_big, e_small;
    bit fire;
    e_big   = (m_cnt > 65535) ? 65535 : m_cnt;
    e_small = (m_cnt > 3) ? 3 : m_cnt;
    if (!areset_n) begin
      m_init = 0; m_hist = 0; m_cnt = 0;
      e_ready = 0; e_taken = 0; e_hist = 0; e_big = 0; e_small = 0;
    end else if (m_init < 128) begin
      e_ready = 0; e_taken = 0; e_hist = 0;
    end else begin
      e_ready = 1;
      fire    = predict_valid;
      idx     = m_hist ^ int'(predict_pc);
      e_taken = fire ? ((m_pht[idx] >= 2) ? 1 : 0) : 0;
      e_hist  = fire ? m_hist : 0;
    end
    check("m_ready",  32'(predict_ready),     32'(e_ready));
    check("m_dbg",    32'(dbg_state),         32'(e_ready));
    check("m_taken",  32'(predict_taken),     32'(e_taken));
    check("m_hist",   32'(predict_history),   32'(e_hist));
    check("m_cnt",    32'(mispredict_count),  32'(e_big));
    check("m_ready2", 32'(predict_ready2),    32'(e_ready));
    check("m_taken2", 32'(predict_taken2),    32'(e_taken));
    check("m_hist2",  32'(predict_history2),  32'(e_hist));
    check("m_cnt2",   32'(mispredict_count2), 32'(e_small));
    if (areset_n) begin
      if (m_init < 128) begin
        m_init++;
        if (m_init == 128) for (int i = 0; i < 128; i++) m_pht[i] = 1;
      end else begin
        if (train_valid) begin
          idx = int'(train_history) ^ int'(train_pc);
          if (train_taken && m_pht[idx] < 3) m_pht[idx]++;
          else if (!train_taken && m_pht[idx] > 0) m_pht[idx]--;
        end
        if (train_valid && train_mispredicted)
          m_hist = ((int'(train_history) << 1) | int'(train_taken)) & 127;
        else if (fire)
          m_hist = ((m_hist << 1) | e_taken) & 127;
        if (clear_stats) m_cnt = 0;
        else if (train_valid && train_mispredicted && m_cnt < 65535) m_cnt++;
      end
    end
  end

  // driver tasks: inputs change just after the rising edge, results read after the falling edge
  task automatic step(input bit pv, input int ppc, input bit tv, input bit tt, input bit tm,
                      input int th, input int tpc, input bit clr);
    @(posedge clk); #1;
    predict_valid      = pv;
    predict_pc         = 7'(ppc);
    train_valid        = tv;
    train_taken        = tt;
    train_mispredicted = tm;
    train_history      = 7'(th);
    train_pc           = 7'(tpc);
    clear_stats        = clr;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic train(input bit tt, input bit tm, input int th, input int tpc);
    step(0, 0, 1, tt, tm, th, tpc, 0);
  endtask

  task automatic pred(input int pc);
    step(1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    @(negedge clk); #1;
    while (!predict_ready && n < 1000) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  initial begin : main
    int n, h;
    areset_n = 1'b0; predict_valid = 1'b0; predict_pc = '0;
    train_valid = 1'b0; train_taken = 1'b0; train_mispredicted = 1'b0;
    train_history = '0; train_pc = '0; clear_stats = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(predict_ready), 0);
    check("rst_cnt",   32'(mispredict_count), 0);

    // release with a request pending: ready stays low for the full sweep
    areset_n = 1'b1; predict_valid = 1'b1; predict_pc = '0;
    wait_init(n);
    check("init_len",    n, 128);
    check("first_taken", 32'(predict_taken), 0);
    check("first_hist",  32'(predict_history), 0);

    // small tally saturates at 3, clear beats a concurrent mispredict
    train(0, 1, 0, 0);
    train(0, 1, 0, 0);
    check("small_cnt1", 32'(mispredict_count2), 1);
    train(0, 1, 0, 0);
    check("small_cnt2", 32'(mispredict_count2), 2);
    train(0, 1, 0, 0);
    check("small_cnt3", 32'(mispredict_count2), 3);
    step(0, 0, 1, 0, 1, 0, 0, 1);
    check("small_sat",  32'(mispredict_count2), 3);
    check("big_cnt4",   32'(mispredict_count), 4);
    idle();
    check("clr_big",    32'(mispredict_count), 0);
    check("clr_small",  32'(mispredict_count2), 0);

    // counter saturation at entry 5
    train(1, 0, 0, 5);
    train(1, 0, 0, 5);
    pred(5);
    check("sat_taken1", 32'(predict_taken), 1);
    train(1, 0, 0, 5);
    train(1, 0, 0, 5);
    train(0, 0, 0, 5);
    pred(4);
    check("sat_top",    32'(predict_taken), 1);
    check("sat_hist1",  32'(predict_history), 1);
    train(0, 0, 0, 5);
    train(0, 0, 0, 5);
    train(0, 0, 0, 5);
    pred(6);
    check("sat_bottom", 32'(predict_taken), 0);
    check("sat_hist3",  32'(predict_history), 3);

    // history repair on mispredict overrides a same-cycle predict shift
    train(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      pred(7'h10);
      check("hist_zero", 32'(predict_history), 0);
    end
    step(1, 7'h10, 1, 1, 1, 7'h15, 7'h20, 0);
    check("repair_cyc", 32'(predict_history), 0);
    pred(0);
    check("repair_hist", 32'(predict_history), 32'h2B);

    // same-cycle predict and train to index 3
    train(0, 1, 0, 0);
    step(1, 3, 1, 1, 0, 0, 3, 0);
    check("bypass_old", 32'(predict_taken), 0);
    train(1, 0, 0, 3);
    pred(3);
    check("bypass_new", 32'(predict_taken), 1);

    train(0, 1, 0, 0);
    train(1, 1, 0, 7'h7F);
    idle();
    check("cnt5",       32'(mispredict_count), 5);
    check("cnt5_small", 32'(mispredict_count2), 3);
    pred(7'h7F);
    check("hist_nz",    32'(predict_history), 1);

    // reset mid-RUN clears outputs immediately
    @(posedge clk); #1;
    areset_n = 1'b0;
    #1;
    check("arst_ready", 32'(predict_ready), 0);
    check("arst_taken", 32'(predict_taken), 0);
    check("arst_hist",  32'(predict_history), 0);
    check("arst_cnt",   32'(mispredict_count), 0);
    repeat (2) @(posedge clk);
    #1;
    areset_n = 1'b1;
    // reset again partway through the sweep
    repeat (40) @(negedge clk);
    @(posedge clk); #1;
    areset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    areset_n = 1'b1;
    wait_init(n);
    check("reinit_len", n, 128);

    // every entry holds 1: not taken before, taken after exactly one taken train
    for (int i = 0; i < 128; i++) begin
      step(1, i, 1, 1, 0, 0, i, 0);
      check("readback_pre", 32'(predict_taken), 0);
    end
    h = 0;
    for (int i = 0; i < 128; i++) begin
      pred(i ^ h);
      check("readback_post", 32'(predict_taken), 1);
      h = ((h << 1) | 1) & 127;
    end

    // randomized traffic, including rare one-cycle resets
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      areset_n           = ($urandom_range(0, 1499) != 0);
      predict_valid      = ($urandom_range(0, 9) < 7);
      predict_pc         = 7'($urandom_range(0, 127));
      train_valid        = ($urandom_range(0, 1) == 1);
      train_taken        = ($urandom_range(0, 1) == 1);
      train_mispredicted = ($urandom_range(0, 9) < 3);
      train_history      = 7'($urandom_range(0, 127));
      train_pc           = 7'($urandom_range(0, 127));
      clear_stats        = ($urandom_range(0, 99) < 3);
    end
    @(posedge clk); #1;
    areset_n = 1'b1;
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
